// File: rtl/transition_encoder_pkg.sv
// Shared definitions for the transition (NRZI-style) encoder.
// Contents:
//   DEF_DATA_W - default parallel word width
//   DEF_CNT_W  - default accepted-word counter width
//   state_t    - encoder FSM states (IDLE, SHIFT)
package transition_encoder_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/transition_encoder.sv
// Transition encoder: serializes parallel words MSB first onto a single line
// where a level change encodes a 1 and no change encodes a 0. All state
// updates happen on the falling edge of sys_clk.
// Ports:
//   sys_clk    in   sole clock (falling-edge active)
//   sys_rst_n  in   asynchronous active-low reset
//   data_in    in   word to transmit, sampled only on accept
//   data_valid in   data_in holds a word to send
//   data_ready out  encoder takes a word on the next falling edge
//   stream     out  encoded serial line
//   busy       out  a word is partially emitted
//   word_count out  words accepted since reset (wrapping)
module transition_encoder
  import transition_encoder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              stream,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count
);

  // bit counter must hold the value DATA_W itself
  localparam int              BCW      = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0]  LAST_CNT = BCW'(DATA_W);
  localparam logic [BCW-1:0]  ONE_CNT  = BCW'(1);

  state_t              r_state;
  logic                r_stream;
  logic [DATA_W-1:0]   r_shreg;
  logic [BCW-1:0]      r_bit_cnt;
  logic [CNT_W-1:0]    r_word_count;

  state_t              w_state_next;
  logic                w_stream_next;
  logic [DATA_W-1:0]   w_shreg_next;
  logic [BCW-1:0]      w_bit_cnt_next;
  logic [CNT_W-1:0]    w_count_next;
  logic                w_at_end;
  logic                w_accept;

  // The last bit of a word is already on the line once bit_cnt reaches
  // DATA_W, so that edge is free to start the next word (gapless streaming).
  assign w_at_end   = (r_bit_cnt == LAST_CNT);
  assign data_ready = (r_state == IDLE) || ((r_state == SHIFT) && w_at_end);
  assign busy       = (r_state == SHIFT) && !w_at_end;
  assign w_accept   = data_valid && data_ready;

  assign stream     = r_stream;
  assign word_count = r_word_count;

  always_ff @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= IDLE;
      r_stream     <= 1'b0;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_word_count <= '0;
    end else begin
      r_state      <= w_state_next;
      r_stream     <= w_stream_next;
      r_shreg      <= w_shreg_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_word_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_stream_next  = r_stream;
    w_shreg_next   = r_shreg;
    w_bit_cnt_next = r_bit_cnt;
    w_count_next   = r_word_count;

    if (w_accept) begin
      // MSB goes out on the accept edge itself; the rest waits in shreg
      w_stream_next  = r_stream ^ data_in[DATA_W-1];
      w_shreg_next   = data_in << 1;
      w_bit_cnt_next = ONE_CNT;
      w_state_next   = SHIFT;
      w_count_next   = r_word_count + CNT_W'(1);
    end else if (r_state == SHIFT) begin
      if (w_at_end) begin
        w_state_next = IDLE;
      end else begin
        w_stream_next  = r_stream ^ r_shreg[DATA_W-1];
        w_shreg_next   = r_shreg << 1;
        w_bit_cnt_next = r_bit_cnt + ONE_CNT;
      end
    end
  end

endmodule

// File: tb/tb_transition_encoder.sv
module tb_transition_encoder;

  logic        clk = 1'b1;
  logic        rst_n;
  logic [7:0]  data;
  logic        valid;
  logic        ready, stream, busy;
  logic [15:0] count;

  // second instance: single-bit words with a narrow counter for wrap checks
  logic        d1_data;
  logic        d1_valid;
  logic        d1_ready, d1_stream, d1_busy;
  logic [7:0]  d1_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  transition_encoder #(.DATA_W(8), .CNT_W(16)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .data_in(data), .data_valid(valid),
    .data_ready(ready), .stream(stream), .busy(busy), .word_count(count)
  );

  transition_encoder #(.DATA_W(1), .CNT_W(8)) dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .data_in(d1_data), .data_valid(d1_valid),
    .data_ready(d1_ready), .stream(d1_stream), .busy(d1_busy), .word_count(d1_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(negedge clk);
    #1;
  endtask

  // one falling edge, returning the bit recovered from the line transition
  task automatic edge_dec(output logic b);
    logic p;
    p = stream;
    edge_step();
    b = stream ^ p;
  endtask

  logic [7:0] exp_a5 [8];
  logic [7:0] rt_words [5];
  int         rt_gaps  [5];

  initial begin
    logic [7:0] dec;
    logic       b;
    logic       lvl;
    logic       exp_s;
    logic       dv;

    exp_a5 = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0};
    rt_words = '{8'h3A, 8'hC7, 8'h01, 8'hFE, 8'h5B};
    rt_gaps  = '{0, 2, 0, 1, 3};

    rst_n = 1'b0; valid = 1'b0; data = 8'h00; d1_valid = 1'b0; d1_data = 1'b0;
    #2;
    check("rst_stream", stream, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 1);
    check("rst_count", count, 0);

    @(posedge clk);
    rst_n = 1'b1;

    // single word A5
    data = 8'hA5; valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      edge_step();
      valid = 1'b0;
      check($sformatf("a5_stream_%0d", k), stream, exp_a5[k]);
      check($sformatf("a5_busy_%0d", k), busy, (k < 7) ? 1 : 0);
    end
    check("a5_ready_end", ready, 1);
    edge_step();
    check("a5_idle_stream", stream, 0);
    check("a5_idle_ready", ready, 1);
    check("a5_count", count, 1);

    // back-to-back FF then 00
    data = 8'hFF; valid = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      edge_step();
      check($sformatf("b2b_stream_%0d", k), stream, (k <= 8) ? (k % 2) : 0);
      check($sformatf("b2b_ready_%0d", k), ready, (k == 8 || k == 16) ? 1 : 0);
      check($sformatf("b2b_busy_%0d", k), busy, (k == 8 || k == 16) ? 0 : 1);
      if (k == 8) data = 8'h00;
    end
    valid = 1'b0;
    check("b2b_count", count, 3);
    edge_step();

    // stall: 3C presented while busy, replaced by 81 before ready
    data = 8'h00; valid = 1'b1;
    edge_dec(b); dec[7] = b;
    data = 8'h3C;
    for (int k = 1; k < 8; k++) begin
      edge_dec(b); dec[7-k] = b;
      check($sformatf("stall_ready_%0d", k), ready, (k == 7) ? 1 : 0);
      if (k == 3) data = 8'h81;
    end
    check("stall_first_word", dec, 8'h00);
    check("stall_count_mid", count, 4);
    for (int k = 0; k < 8; k++) begin
      edge_dec(b); dec[7-k] = b;
      valid = 1'b0;
    end
    check("stall_word", dec, 8'h81);
    check("stall_count", count, 5);

    // reset in the middle of F0
    data = 8'hF0; valid = 1'b1;
    edge_step();
    valid = 1'b0;
    edge_step();
    edge_step();
    check("rmw_stream_pre", stream, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rmw_stream", stream, 0);
    check("rmw_busy", busy, 0);
    check("rmw_ready", ready, 1);
    check("rmw_count", count, 0);
    edge_step();
    check("rmw_hold", stream, 0);
    #6 rst_n = 1'b1;
    data = 8'h80; valid = 1'b1;
    edge_step();
    valid = 1'b0;
    check("rmw_80_first", stream, 1);
    for (int k = 1; k < 8; k++) begin
      edge_step();
      check($sformatf("rmw_80_bit%0d", k), stream, 1);
    end
    check("rmw_80_count", count, 1);

    // round trip through a transition detector with gaps
    for (int w = 0; w < 5; w++) begin
      valid = 1'b0;
      for (int g = 0; g < rt_gaps[w]; g++) begin
        lvl = stream;
        edge_step();
        check($sformatf("rt_idle_hold_%0d_%0d", w, g), stream, lvl);
      end
      data = rt_words[w]; valid = 1'b1;
      check($sformatf("rt_ready_%0d", w), ready, 1);
      for (int k = 0; k < 8; k++) begin
        edge_dec(b); dec[7-k] = b;
        valid = 1'b0;
      end
      check($sformatf("rt_word_%0d", w), dec, rt_words[w]);
    end
    check("rt_count", count, 6);

    // DATA_W=1 instance: ready always high, count wraps at 256
    exp_s = 1'b0;
    for (int i = 0; i < 256; i++) begin
      dv = (i % 3 == 0);
      d1_data = dv; d1_valid = 1'b1;
      edge_step();
      exp_s = exp_s ^ dv;
      check($sformatf("w1_stream_%0d", i), d1_stream, exp_s);
      check($sformatf("w1_ready_%0d", i), d1_ready, 1);
      check($sformatf("w1_busy_%0d", i), d1_busy, 0);
      if (i == 254) check("w1_count_max", d1_count, 8'hFF);
    end
    check("w1_count_wrap", d1_count, 0);
    d1_valid = 1'b0;
    edge_step();
    check("w1_idle_stream", d1_stream, exp_s);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
